// File: rtl/bp_fe_bht_gshare.sv
// bp_fe_bht_gshare
//   gshare branch history table for the fetch stage. Each entry is a
//   ctr_width_p-bit saturating counter indexed by (PC index ^ global history).
//   Prediction is registered (one cycle after r_v_i). The table initialises
//   itself with a sweep after every reset, writing "weakly not-taken".
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   init_done_o           table sweep finished; 0 during reset and sweep
//   r_v_i, r_idx_i        prediction request and PC-derived index
//   spec_v_i, spec_taken_i  speculative direction shifted into history
//   predict_v_o, predict_o, ghist_o
//                         prediction valid / taken / history snapshot used
//   w_v_i, w_idx_i, w_ghist_i, w_taken_i, w_mispredict_i
//                         training update; mispredict also repairs history
//
// Build option
//   BP_FE_BHT_BYPASS_EN   when defined, a read that hits the entry being
//                         written in the same cycle sees the updated counter.
module bp_fe_bht_gshare #(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 8,
  parameter int ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [ghist_width_p-1:0]   ghist_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i,
  input  logic                       w_mispredict_i
);
  localparam int els_lp = 1 << bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] ctr_init_lp = {1'b0, {(ctr_width_p-1){1'b1}}};
  localparam logic [ctr_width_p-1:0] ctr_max_lp  = '1;

  typedef enum logic {e_init, e_ready} state_e;

  state_e                       state_r, state_n;
  logic [bht_idx_width_p-1:0]   sweep_cnt_r;
  logic [ghist_width_p-1:0]     ghist_r, ghist_n;
  logic [ctr_width_p-1:0]       mem [els_lp];

  logic                         ready;
  logic [bht_idx_width_p-1:0]   r_hash, w_hash, mem_waddr;
  logic [ctr_width_p-1:0]       w_ctr_old, w_ctr_new, mem_wdata;
  logic                         mem_we, r_bit;

  // History is zero-extended into the upper index bits before the XOR.
  function automatic logic [bht_idx_width_p-1:0] hash_f(
    input logic [bht_idx_width_p-1:0] x, input logic [ghist_width_p-1:0] h);
    logic [bht_idx_width_p-1:0] hx;
    hx = '0;
    hx[ghist_width_p-1:0] = h;
    return x ^ hx;
  endfunction

  // Shift in a new bit; the {h,b} concat keeps this valid for 1-bit history.
  function automatic logic [ghist_width_p-1:0] shift_f(
    input logic [ghist_width_p-1:0] h, input logic b);
    logic [ghist_width_p:0] t;
    t = {h, b};
    return t[ghist_width_p-1:0];
  endfunction

  assign ready       = (state_r == e_ready);
  assign init_done_o = ready;

  // FSM next state
  always_comb begin
    state_n = state_r;
    if (state_r == e_init && sweep_cnt_r == '1) state_n = e_ready;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_init;
      sweep_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (!ready) sweep_cnt_r <= sweep_cnt_r + 1'b1;
    end
  end

  // Training: read-modify-write on the write-hashed entry
  always_comb begin
    r_hash    = hash_f(r_idx_i, ghist_r);
    w_hash    = hash_f(w_idx_i, w_ghist_i);
    w_ctr_old = mem[w_hash];
    w_ctr_new = w_ctr_old;
    if (w_taken_i) begin
      if (w_ctr_old != ctr_max_lp) w_ctr_new = w_ctr_old + 1'b1;
    end else begin
      if (w_ctr_old != '0) w_ctr_new = w_ctr_old - 1'b1;
    end
    // The sweep owns the write port until the table is ready.
    mem_we    = !ready || w_v_i;
    mem_waddr = ready ? w_hash : sweep_cnt_r;
    mem_wdata = ready ? w_ctr_new : ctr_init_lp;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read data, optionally forwarded from the concurrent write
  always_comb begin
    r_bit = mem[r_hash][ctr_width_p-1];
`ifdef BP_FE_BHT_BYPASS_EN
    if (ready && w_v_i && (w_hash == r_hash)) r_bit = w_ctr_new[ctr_width_p-1];
`endif
  end

  // History: repair wins over a same-cycle speculative shift
  always_comb begin
    ghist_n = ghist_r;
    if (ready) begin
      if (w_v_i && w_mispredict_i) ghist_n = shift_f(w_ghist_i, w_taken_i);
      else if (spec_v_i)           ghist_n = shift_f(ghist_r, spec_taken_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ghist_r     <= '0;
      predict_v_o <= 1'b0;
      predict_o   <= 1'b0;
      ghist_o     <= '0;
    end else begin
      ghist_r     <= ghist_n;
      predict_v_o <= ready && r_v_i;
      if (ready && r_v_i) begin
        predict_o <= r_bit;
        ghist_o   <= ghist_r;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
module tb_bp_fe_bht_gshare;
`ifdef BP_FE_BHT_BYPASS_EN
  localparam bit byp = 1'b1;
`else
  localparam bit byp = 1'b0;
`endif

  logic       clk_i = 1'b0, reset_i = 1'b1;
  logic       init_done_o, predict_v_o, predict_o;
  logic [1:0] ghist_o;
  logic       r_v_i = 0, spec_v_i = 0, spec_taken_i = 0;
  logic       w_v_i = 0, w_taken_i = 0, w_mispredict_i = 0;
  logic [3:0] r_idx_i = 0, w_idx_i = 0;
  logic [1:0] w_ghist_i = 0;

  int n_vec = 0, n_err = 0;
  int mc[16];      // reference counters
  int mg;          // reference global history

  bp_fe_bht_gshare #(.bht_idx_width_p(4), .ghist_width_p(2), .ctr_width_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .r_idx_i(r_idx_i), .spec_v_i(spec_v_i), .spec_taken_i(spec_taken_i),
    .predict_v_o(predict_v_o), .predict_o(predict_o), .ghist_o(ghist_o),
    .w_v_i(w_v_i), .w_idx_i(w_idx_i), .w_ghist_i(w_ghist_i), .w_taken_i(w_taken_i),
    .w_mispredict_i(w_mispredict_i));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mc[i] = 1;
    mg = 0;
  endtask

  // One ready-state cycle: drive, predict from the model, clock, compare.
  task automatic cyc(input bit rv, input int ridx, input bit sv, input bit st,
                     input bit wv, input int widx, input int wg, input bit wt, input bit wm);
    int rh, wh, newc, ep, eg;
    r_v_i = rv; r_idx_i = 4'(ridx); spec_v_i = sv; spec_taken_i = st;
    w_v_i = wv; w_idx_i = 4'(widx); w_ghist_i = 2'(wg); w_taken_i = wt; w_mispredict_i = wm;
    rh   = ridx ^ mg;
    wh   = widx ^ wg;
    newc = wt ? (mc[wh] == 3 ? 3 : mc[wh] + 1) : (mc[wh] == 0 ? 0 : mc[wh] - 1);
    ep   = (mc[rh] >= 2) ? 1 : 0;
    if (byp && wv && wh == rh) ep = (newc >= 2) ? 1 : 0;
    eg   = mg;
    if (wv) mc[wh] = newc;
    if (wv && wm)  mg = ((wg * 2) + int'(wt)) % 4;
    else if (sv)   mg = ((mg * 2) + int'(st)) % 4;
    @(posedge clk_i); #1;
    chk("predict_v", int'(predict_v_o), int'(rv));
    if (rv) begin
      chk("predict", int'(predict_o), ep);
      chk("ghist_o", int'(ghist_o), eg);
    end
  endtask

  task automatic rd(input int ridx);
    cyc(1, ridx, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, int'(init_done_o), 0);
    chk({tag, "_pv"}, int'(predict_v_o), 0);
    chk({tag, "_p"}, int'(predict_o), 0);
    chk({tag, "_g"}, int'(ghist_o), 0);
  endtask

  initial begin
    #12;
    chk_zero("rst");
    // Reset mid-sweep: abort at cycle 9, then a full sweep must follow.
    @(negedge clk_i); reset_i = 0;
    repeat (9) @(posedge clk_i);
    #1;
    chk("mid_done_pre", int'(init_done_o), 0);
    reset_i = 1; #1;
    chk_zero("midrst");
    @(negedge clk_i); @(negedge clk_i); reset_i = 0;
    r_v_i = 1; r_idx_i = 4'd5; spec_v_i = 1; spec_taken_i = 1; w_v_i = 1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_i); #1;
      chk("sweep_done", int'(init_done_o), (k == 16) ? 1 : 0);
      chk("sweep_pv", int'(predict_v_o), 0);
    end
    model_reset();
    // Every entry starts weakly not-taken; no history was shifted during sweep.
    for (int i = 0; i < 16; i++) begin
      rd(i);
      chk("init_read", int'(predict_o), 0);
    end
    // Saturation on entry 3 (ghist = 0)
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 3, 0, 1, 0); rd(3); chk("sat_up", int'(predict_o), 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 3, 0, 0, 0); rd(3); chk("sat_dn", int'(predict_o), (i == 0) ? 1 : 0);
    end
    // Hashing: ghist=11, idx 4 -> entry 7
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    rd(4); chk("hash_g", int'(ghist_o), 3); chk("hash_p0", int'(predict_o), 0);
    cyc(0, 0, 0, 0, 1, 4, 3, 1, 0);
    rd(4); chk("hash_e7", int'(predict_o), 1);
    rd(7); chk("hash_e4", int'(predict_o), 0);
    // Repair priority: ghist 11 -> 10, then repair to {1,0} beats spec shift
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 1, 0, 1);
    rd(0); chk("repair_g", int'(ghist_o), 2);
    // Collision on entry 6 (ghist=10, idx 4)
    cyc(1, 4, 0, 0, 1, 4, 2, 1, 0);
    chk("coll_same", int'(predict_o), byp ? 1 : 0);
    rd(4); chk("coll_next", int'(predict_o), 1);
    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), int'($urandom_range(15)), 1'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(15)), int'($urandom_range(3)), 1'($urandom),
          ($urandom_range(3) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
